cmm_cplx_accum: RTL and testbench

//  Downstream of the complex multiplier: sums ACC_LEN consecutive 80-bit products ({imag40,real40}) into one

---
 rtl/cmm_pkg.sv | 23 ++
 rtl/cmm_round_sat.sv | 52 +++++
 rtl/cmm_cplx_accum.sv | 171 +++++++++++++++++
 tb/tb_cmm_cplx_accum.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmm_pkg.sv
// -----------------------------------------------------------------------------
// cmm_pkg
// Shared constants for the complex-matrix-multiply (CMM) datapath.
//   CMM_PROD_W  : signed width of one component of a multiplier product
//   CMM_SAMP_W  : signed width of one component of a sample word
//   CMM_RE_IDX / CMM_IM_IDX : field index of the real / imaginary part in a
//                 packed {imag, real} word
//   cmm_field_lsb() : LSB position of a field given component width and index
// -----------------------------------------------------------------------------
package cmm_pkg;

    localparam int CMM_PROD_W = 40;
    localparam int CMM_SAMP_W = 16;

    // Packed complex words are {imag, real}: real in the low field.
    localparam int CMM_RE_IDX = 0;
    localparam int CMM_IM_IDX = 1;

    function automatic int cmm_field_lsb(input int comp_w, input int field_idx);
        return comp_w * field_idx;
    endfunction

endpackage : cmm_pkg

// File: rtl/cmm_round_sat.sv
// -----------------------------------------------------------------------------
// cmm_round_sat
// Combinational round-half-up, arithmetic right shift by SHIFT, then clamp to
// the signed OUT-bit range.
// Parameters:
//   IN     signed input width
//   OUT    signed output width (must not exceed IN + 1 - SHIFT + ... ; any
//          OUT <= IN is safe)
//   SHIFT  right shift amount, >= 1
// Ports:
//   i_val    in   IN   signed value to round and saturate
//   o_val    out  OUT  rounded, clamped value
//   o_clamp  out  1    high when o_val was clamped to a range limit
// -----------------------------------------------------------------------------
module cmm_round_sat #(
    parameter int IN    = 42,
    parameter int OUT   = 16,
    parameter int SHIFT = 15
) (
    input  logic signed [IN-1:0]  i_val,
    output logic signed [OUT-1:0] o_val,
    output logic                  o_clamp
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int EXT_W = IN + 1;

    localparam logic signed [EXT_W-1:0] RND   = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT+1){1'b0}}, {(OUT-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT+1){1'b1}}, {(OUT-1){1'b0}}};

    logic signed [EXT_W-1:0] w_biased;
    logic signed [EXT_W-1:0] w_shifted;

    assign w_biased  = {i_val[IN-1], i_val} + RND;
    assign w_shifted = w_biased >>> SHIFT;

    // NOTE: every output of an always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        o_val   = w_shifted[OUT-1:0];
        o_clamp = 1'b0;
        if (w_shifted > MAX_V) begin
            o_val   = MAX_V[OUT-1:0];
            o_clamp = 1'b1;
        end else if (w_shifted < MIN_V) begin
            o_val   = MIN_V[OUT-1:0];
            o_clamp = 1'b1;
        end
    end

endmodule : cmm_round_sat

// File: rtl/cmm_cplx_accum.sv
// -----------------------------------------------------------------------------
// cmm_cplx_accum
// Accumulates ACC_LEN consecutive complex products ({imag, real}, IN_W bits
// each) into one dot product, then rounds/saturates it to an {imag, real}
// sample word of OUT_W bits per component. AXI-stream slave in, AXI-stream
// master out, one output register; result valid one cycle after the last
// accepted beat of a group.
//
// Configuration macro: CMM_ACC_OVF_EN
//   defined   -> ovf_sticky port present: set whenever a loaded result had
//                either component clamped, cleared only by areset.
//   undefined -> no ovf_sticky port; datapath identical.
//
// Ports:
//   aclk           in   1        clock, rising edge
//   areset         in   1        synchronous reset, active-high
//   aclken         in   1        clock enable; low freezes all state
//   s_axis_tvalid  in   1        product valid
//   s_axis_tready  out  1        product accepted
//   s_axis_tdata   in   2*IN_W   {imag, real} product, two's complement
//   m_axis_tvalid  out  1        result valid
//   m_axis_tready  in   1        downstream accepts result
//   m_axis_tdata   out  2*OUT_W  {imag, real} rounded/saturated result
//   ovf_sticky     out  1        (CMM_ACC_OVF_EN only) saturation seen
// -----------------------------------------------------------------------------
module cmm_cplx_accum
    import cmm_pkg::*;
#(
    parameter int ACC_LEN = 4,
    parameter int IN_W    = CMM_PROD_W,
    parameter int OUT_W   = CMM_SAMP_W,
    parameter int SHIFT   = 15
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 aclken,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [2*IN_W-1:0]    s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [2*OUT_W-1:0]   m_axis_tdata
`ifdef CMM_ACC_OVF_EN
    ,
    output logic                 ovf_sticky
`endif
);

    // Extra bit on top of the growth bits: the running sum never wraps.
    localparam int ACC_W = IN_W + $clog2(ACC_LEN) + 1;
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    localparam int IN_RE_LSB  = cmm_field_lsb(IN_W,  CMM_RE_IDX);
    localparam int IN_IM_LSB  = cmm_field_lsb(IN_W,  CMM_IM_IDX);
    localparam int OUT_RE_LSB = cmm_field_lsb(OUT_W, CMM_RE_IDX);
    localparam int OUT_IM_LSB = cmm_field_lsb(OUT_W, CMM_IM_IDX);

    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc_re;
    logic signed [ACC_W-1:0] r_acc_im;
    logic                    r_m_valid;
    logic [2*OUT_W-1:0]      r_m_data;

    logic signed [IN_W-1:0]  w_prod_re;
    logic signed [IN_W-1:0]  w_prod_im;
    logic signed [ACC_W-1:0] w_sum_re;
    logic signed [ACC_W-1:0] w_sum_im;
    logic signed [OUT_W-1:0] w_res_re;
    logic signed [OUT_W-1:0] w_res_im;
    logic                    w_clamp_re;
    logic                    w_clamp_im;
    logic                    w_last;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [2*OUT_W-1:0]      w_res_word;

    assign w_prod_re = s_axis_tdata[IN_RE_LSB +: IN_W];
    assign w_prod_im = s_axis_tdata[IN_IM_LSB +: IN_W];

    assign w_sum_re = r_acc_re + {{(ACC_W-IN_W){w_prod_re[IN_W-1]}}, w_prod_re};
    assign w_sum_im = r_acc_im + {{(ACC_W-IN_W){w_prod_im[IN_W-1]}}, w_prod_im};

    assign w_last = (r_cnt == CNT_LAST);

    // Only a group-closing beat needs the output register; it stalls while
    // that register holds a result that is not draining this cycle.
    assign s_axis_tready = aclken & ~(w_last & r_m_valid & ~m_axis_tready);
    assign w_in_fire     = aclken & s_axis_tvalid & s_axis_tready;
    assign w_out_fire    = aclken & r_m_valid & m_axis_tready;

    cmm_round_sat #(
        .IN    (ACC_W),
        .OUT   (OUT_W),
        .SHIFT (SHIFT)
    ) u_rs_re (
        .i_val   (w_sum_re),
        .o_val   (w_res_re),
        .o_clamp (w_clamp_re)
    );

    cmm_round_sat #(
        .IN    (ACC_W),
        .OUT   (OUT_W),
        .SHIFT (SHIFT)
    ) u_rs_im (
        .i_val   (w_sum_im),
        .o_val   (w_res_im),
        .o_clamp (w_clamp_im)
    );

    always_comb begin
        w_res_word = '0;
        w_res_word[OUT_RE_LSB +: OUT_W] = w_res_re;
        w_res_word[OUT_IM_LSB +: OUT_W] = w_res_im;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt     <= '0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (aclken) begin
            if (w_out_fire) begin
                r_m_valid <= 1'b0;
            end
            if (w_in_fire) begin
                if (w_last) begin
                    // Later assignment wins: a drain and a new result in the
                    // same cycle keep valid high with no bubble.
                    r_m_data  <= w_res_word;
                    r_m_valid <= 1'b1;
                    r_acc_re  <= '0;
                    r_acc_im  <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc_re <= w_sum_re;
                    r_acc_im <= w_sum_im;
                    r_cnt    <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;

`ifdef CMM_ACC_OVF_EN
    logic r_ovf;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ovf <= 1'b0;
        end else if (w_in_fire && w_last && (w_clamp_re || w_clamp_im)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_sticky = r_ovf;
`else
    // Clamp flags have no consumer without the sticky flag; this OR is
    // removed by synthesis.
    logic w_unused_clamp;
    assign w_unused_clamp = w_clamp_re | w_clamp_im;
`endif

endmodule : cmm_cplx_accum

// File: tb/tb_cmm_cplx_accum.sv
// -----------------------------------------------------------------------------
// tb_cmm_cplx_accum
// Self-checking bench for cmm_cplx_accum (ACC_LEN=4, IN_W=40, OUT_W=16,
// SHIFT=15). A behavioural model (group sums in longint arithmetic and a queue
// of pending results) is compared against the DUT every cycle; directed
// scenarios pin literal results. Honours CMM_ACC_OVF_EN for ovf_sticky.
// -----------------------------------------------------------------------------
module tb_cmm_cplx_accum;

    localparam int ACC_LEN = 4;
    localparam int IN_W    = 40;
    localparam int OUT_W   = 16;
    localparam int SHIFT   = 15;
    localparam longint OMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint OMIN = -(longint'(1) <<< (OUT_W - 1));

    logic                aclk = 1'b0;
    logic                areset;
    logic                aclken;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic [2*IN_W-1:0]   s_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic [2*OUT_W-1:0]  m_axis_tdata;
`ifdef CMM_ACC_OVF_EN
    logic                ovf_sticky;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state
    int              grp_n = 0;
    longint          sum_re = 0;
    longint          sum_im = 0;
    logic [31:0]     exp_q[$];
    logic [31:0]     got_q[$];
    bit              exp_ovf = 0;

    always #5 aclk = ~aclk;

    cmm_cplx_accum #(
        .ACC_LEN (ACC_LEN),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .aclken        (aclken),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
`ifdef CMM_ACC_OVF_EN
        ,
        .ovf_sticky    (ovf_sticky)
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Round half up, shift, clamp: straight from the arithmetic definition.
    function automatic void round_sat(input longint s, output logic [15:0] v, output bit c);
        longint t;
        t = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        c = 1'b0;
        if (t > OMAX) begin t = OMAX; c = 1'b1; end
        else if (t < OMIN) begin t = OMIN; c = 1'b1; end
        v = t[15:0];
    endfunction

    function automatic logic [31:0] result_word(input longint re, input longint im);
        logic [15:0] vr, vi;
        bit cr, ci;
        round_sat(re, vr, cr);
        round_sat(im, vi, ci);
        return {vi, vr};
    endfunction

    function automatic bit result_clamped(input longint re, input longint im);
        logic [15:0] vr, vi;
        bit cr, ci;
        round_sat(re, vr, cr);
        round_sat(im, vi, ci);
        return cr | ci;
    endfunction

    function automatic longint rnd_val();
        longint v;
        case ($urandom_range(0, 3))
            0: begin
                v = longint'({$urandom, $urandom});
                v = (v <<< 24) >>> 24;
            end
            1: v = longint'($urandom_range(0, 32'h7FFF_FFFF)) - 64'sd1073741824;
            default: v = longint'($urandom_range(0, 32'h000F_FFFF)) - 64'sd524288;
        endcase
        return v;
    endfunction

    // Compare process: one cycle-by-cycle comparison, 1 time unit before each
    // rising edge, followed by the model update for that edge.
    initial begin : compare
        bit exp_valid, exp_ready, in_fire, out_fire;
        longint pre, pim;
        @(posedge aclk);
        forever begin
            @(negedge aclk);
            #4;
            exp_valid = (exp_q.size() != 0);
            exp_ready = aclken && !((grp_n == ACC_LEN - 1) && exp_valid && !m_axis_tready);
            check("s_tready", s_axis_tready, exp_ready);
            check("m_tvalid", m_axis_tvalid, exp_valid);
            if (exp_valid) check("m_tdata", m_axis_tdata, exp_q[0]);
`ifdef CMM_ACC_OVF_EN
            check("ovf_sticky", ovf_sticky, exp_ovf);
`endif
            if (areset) begin
                grp_n  = 0;
                sum_re = 0;
                sum_im = 0;
                exp_q.delete();
                exp_ovf = 0;
            end else begin
                out_fire = aclken && exp_valid && m_axis_tready;
                in_fire  = aclken && s_axis_tvalid && exp_ready;
                if (out_fire) begin
                    got_q.push_back(m_axis_tdata);
                    void'(exp_q.pop_front());
                end
                if (in_fire) begin
                    pre = longint'($signed(s_axis_tdata[IN_W-1:0]));
                    pim = longint'($signed(s_axis_tdata[2*IN_W-1:IN_W]));
                    sum_re += pre;
                    sum_im += pim;
                    grp_n++;
                    if (grp_n == ACC_LEN) begin
                        exp_q.push_back(result_word(sum_re, sum_im));
                        if (result_clamped(sum_re, sum_im)) exp_ovf = 1;
                        grp_n  = 0;
                        sum_re = 0;
                        sum_im = 0;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input longint re, input longint im);
        int  n;
        logic ok;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {im[IN_W-1:0], re[IN_W-1:0]};
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            #4;
            ok = s_axis_tready;
            @(negedge aclk);
            n++;
        end
        s_axis_tvalid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=no_accept exp=accept at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle(2);
        areset = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        areset        = 1'b1;
        aclken        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        idle(3);
        areset = 1'b0;

        // Reset state
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        #1;
        check("rst_tready", s_axis_tready, 1'b1);
        @(negedge aclk);

        // Pin the model with hand-computed values
        check("model_basic", result_word(131072, -131072), 32'hFFFC_0004);
        check("model_round", result_word(16384, -16384), 32'h0000_0001);
        check("model_sat", result_word(64'sd4294967296, -64'sd4294967296), 32'h8000_7FFF);
        check("model_clamp_flag", result_clamped(64'sd4294967296, 0), 1'b1);

        // 1: basic group, latency one cycle after last beat
        base = got_q.size();
        repeat (3) send(32768, -32768);
        check("t1_not_early", m_axis_tvalid, 1'b0);
        send(32768, -32768);
        check("t1_valid_lat", m_axis_tvalid, 1'b1);
        check("t1_data_lat", m_axis_tdata, 32'hFFFC_0004);
        idle(2);
        check("t1_count", got_q.size(), base + 1);
        check("t1_result", got_q[$], 32'hFFFC_0004);

        // 2: rounding half up
        send(16384, -16384);
        repeat (3) send(0, 0);
        idle(2);
        check("t2_result", got_q[$], 32'h0000_0001);

        // 3: saturation (and sticky flag)
        repeat (4) send(64'sd1073741824, -64'sd1073741824);
        idle(2);
        check("t3_result", got_q[$], 32'h8000_7FFF);
`ifdef CMM_ACC_OVF_EN
        check("t3_ovf", ovf_sticky, 1'b1);
`endif

        // 4: backpressure, 8 back-to-back beats, 8th stalls
        base = got_q.size();
        m_axis_tready = 1'b0;
        fork
            begin
                repeat (4) send(32768, 0);
                repeat (4) send(65536, 0);
            end
            begin
                idle(14);
                check("t4_held_valid", m_axis_tvalid, 1'b1);
                check("t4_held_data", m_axis_tdata, 32'h0000_0004);
                #1;
                check("t4_stall", s_axis_tready, 1'b0);
                m_axis_tready = 1'b1;
            end
        join
        idle(3);
        check("t4_count", got_q.size(), base + 2);
        check("t4_first", got_q[base], 32'h0000_0004);
        check("t4_second", got_q[base+1], 32'h0000_0008);

        // 5: clock enable low for 5 cycles after beat 2
        send(40000, -1000);
        send(50000, -2000);
        aclken        = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {40'sd12345, 40'sd12345};
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_frozen_tready", s_axis_tready, 1'b0);
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        aclken        = 1'b1;
        send(60000, -3000);
        send(70000, -4000);
        idle(2);
        check("t5_result", got_q[$], 32'h0000_0007);

        // 6: reset drops a pending result and a partial group
        base = got_q.size();
        m_axis_tready = 1'b0;
        repeat (4) send(32768, 0);
        repeat (2) send(1000, 0);
        do_reset();
        check("t6_drop_valid", m_axis_tvalid, 1'b0);
`ifdef CMM_ACC_OVF_EN
        check("t6_ovf_clear", ovf_sticky, 1'b0);
`endif
        m_axis_tready = 1'b1;
        repeat (4) send(32768, 0);
        idle(2);
        check("t6_count", got_q.size(), base + 1);
        check("t6_result", got_q[$], 32'h0000_0004);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            longint r, i;
            r = rnd_val();
            i = rnd_val();
            aclken        = ($urandom_range(0, 9) != 0);
            s_axis_tvalid = ($urandom_range(0, 9) < 7);
            s_axis_tdata  = {i[IN_W-1:0], r[IN_W-1:0]};
            m_axis_tready = ($urandom_range(0, 9) < 6);
            areset        = ($urandom_range(0, 399) == 0);
            @(negedge aclk);
        end
        areset        = 1'b0;
        aclken        = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cmm_cplx_accum
